cdb_arbiter: RTL



---
 rtl/cdb_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per producer, one grant per cycle.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROB_W   = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clr_in,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_result,
  input  logic [NUM_SRC*ROB_W-1:0]  src_rob_index,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [ROB_W-1:0]          cdb_rob_index
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] buf_valid;
  logic [DATA_W-1:0]  buf_result [NUM_SRC];
  logic [ROB_W-1:0]   buf_rob    [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [PTR_W-1:0]   cand;
  logic [NUM_SRC-1:0] take;

  // First occupied buffer at or after rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      cand = PTR_W'((32'(rr_ptr) + off) % NUM_SRC);
      if (!grant_any && buf_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // A granted buffer frees up this cycle, so it may be refilled at the same edge.
  assign src_ready = {NUM_SRC{rdy_in & ~clr_in}} & (~buf_valid | grant);
  assign take      = src_valid & src_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      buf_valid     <= '0;
      cdb_valid     <= 1'b0;
      cdb_result    <= '0;
      cdb_rob_index <= '0;
    end else if (clr_in) begin
      buf_valid <= '0;
      cdb_valid <= 1'b0;
    end else if (rdy_in) begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_result    <= buf_result[grant_idx];
        cdb_rob_index <= buf_rob[grant_idx];
      end
      buf_valid <= (buf_valid & ~grant) | take;
    end
  end

  // Payload registers need no reset; buf_valid qualifies them.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (take[i]) begin
        buf_result[i] <= src_result[i*DATA_W +: DATA_W];
        buf_rob[i]    <= src_rob_index[i*ROB_W +: ROB_W];
      end
    end
  end

`ifdef CDB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
    end else if (clr_in) begin
      rr_ptr <= '0;
    end else if (rdy_in && grant_any) begin
      rr_ptr <= PTR_W'((32'(grant_idx) + 32'd1) % NUM_SRC);
    end
  end
`endif

endmodule
